sort_drain: RTL and testbench
=============================

SORT_DRAIN -- requirements
Module: sort_drain

Interface
REQ-001 Parameters M, N and W SHALL be taken from sort_pkg; local parameter FIFO_DEPTH SHALL default to 4 (a power of two, at least 2) and sets the capacity in frames.
REQ-002 clk  input  1  clock; all state SHALL be updated on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_vld  input  1  valid tag for the vector presented on the sort pipeline's i_chi in the same cycle.
REQ-005 i_y_q  input  W x N  skewed per-stage maxima from the sort pipeline; lane 0 = largest.
REQ-006 o_data  output  N  current serialized element.
REQ-007 o_valid  output  1  o_data is valid.
REQ-008 i_ready  input  1  downstream accepts o_data.
REQ-009 o_idx  output  clog2(W)  rank of o_data within its frame; 0 = largest.
REQ-010 o_last  output  1  high with the element that has rank W-1.
REQ-011 o_ovf  output  1  sticky flag: at least one frame has been dropped.
REQ-012 o_level  output  clog2(FIFO_DEPTH)+1  number of frames held.

Function
REQ-013 Lane i of i_y_q is valid at cycle t+1+i for a vector entered at cycle t; lane i SHALL pass through W-1-i registers so that all W lanes align at cycle t+W.
REQ-014 i_vld SHALL pass through a W-stage shift register so that the delayed tag marks the aligned frame at cycle t+W.
REQ-015 An aligned frame with its delayed tag high SHALL be written into the frame FIFO at the end of cycle t+W.
REQ-016 Frames entered with i_vld low SHALL never be written.
REQ-017 Push when full with no pop in the same cycle: the frame SHALL be dropped, o_ovf SHALL set, and FIFO contents SHALL be unchanged.
REQ-018 Push when full in the same cycle that the last element of the head frame is accepted: the push SHALL succeed and o_level SHALL be unchanged.
REQ-019 The serializer SHALL be a two-state FSM:
  - IDLE -> SEND when the FIFO is not empty.
  - SEND -> IDLE when the element with rank W-1 is accepted and the FIFO becomes empty.
  - Otherwise SEND is held.
REQ-020 In SEND, o_valid SHALL be 1 and o_data SHALL equal head-frame lane o_idx.
REQ-021 o_idx SHALL increment on each o_valid & i_ready handshake and wrap from W-1 to 0, at which point the head frame SHALL be popped.
REQ-022 While o_valid is high and i_ready is low, o_data, o_idx and o_last SHALL hold stable.
REQ-023 Frames SHALL leave in arrival order and elements in rank order 0..W-1, with no bubble between back-to-back frames when i_ready is held high.
REQ-024 Minimum latency: a vector entered at cycle t SHALL present its rank-0 element on o_valid at cycle t+W+1.
REQ-025 o_ovf SHALL be cleared only by reset.
REQ-026 FIFO read and write pointers SHALL each be clog2(FIFO_DEPTH)+1 bits wide, with full and empty decided by comparing the MSB and the remaining bits.

Reset
REQ-027 On rst_n low, all of the following SHALL clear asynchronously to 0, and the FSM SHALL go to IDLE:
  - deskew registers and the valid shift register;
  - FIFO pointers and o_level;
  - o_valid, o_data, o_idx, o_last and o_ovf.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and all queued frames; after release, output SHALL resume only for vectors entered after release.

Structure
REQ-029 M, N and W SHALL stay in sort_pkg; sort_pkg SHALL add a frame typedef (W x N packed) and the function clog2 used for widths.
REQ-030 sort_drain SHALL instantiate exactly one sub-module, sort_frame_fifo: a parameterized synchronous FIFO of frames with push, pop, full, empty and level ports.

Verification
Parameters for all scenarios: M=8, N=8, W=4, FIFO_DEPTH=4.
REQ-031 Single vector {9,3,7,1,15,0,2,4} with i_vld=1, i_ready=1 -> o_data 15,9,7,4 at cycles t+5..t+8, o_idx 0..3, o_last only on 4, o_ovf=0.
REQ-032 Back-to-back vectors at cycles t and t+1 with i_ready=1 -> 8 consecutive valid beats with no gap, first frame first.
REQ-033 i_ready=0 from cycle t+5 for 3 cycles -> o_data stays 15 with o_idx=0; the remaining beats follow in order after i_ready rises.
REQ-034 i_ready=0 with 5 valid vectors on consecutive cycles -> o_level saturates at 4, o_ovf=1, and only the first 4 frames are output after i_ready rises.
REQ-035 Full FIFO with i_ready=1 at the last beat of the head frame coincident with a push -> no drop, o_ovf stays 0.
REQ-036 rst_n pulsed low while o_idx=2 -> outputs go to 0 immediately; no stale beats after release.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg -- shared parameters and helpers for the sort pipeline blocks.
//   M          : elements per input vector of the sort pipeline
//   N          : element width in bits
//   W          : number of ranked maxima produced per vector (frame width)
//   frame_t    : one aligned frame, lane 0 = largest element
//   clog2()    : ceiling log2, used for index, pointer and level widths
package sort_pkg;

  localparam int M = 8;
  localparam int N = 8;
  localparam int W = 4;

  typedef logic [W-1:0][N-1:0] frame_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sort_frame_fifo.sv
// sort_frame_fifo -- synchronous FIFO holding whole frames.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write a frame; ignored when full unless a pop happens
//                in the same cycle
//   pop/rdata  : rdata always shows the head frame; pop advances it
//   full/empty : occupancy flags
//   level      : number of frames held
module sort_frame_fifo
  import sort_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FW-1:0]         wdata,
  input  logic                  pop,
  output logic [FW-1:0]         rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // The extra pointer MSB tells a wrapped-full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO
  // can reuse it on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sort_drain.sv
// sort_drain -- deskews the sort pipeline's per-stage maxima into frames,
// queues them and serializes each frame one element per handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_vld      : tag for the vector entering the sort pipeline this cycle
//   i_y_q      : W lanes of N bits, lane i arrives i+1 cycles after entry
//   o_data     : current element, o_valid qualifies it, i_ready accepts it
//   o_idx      : rank of o_data within its frame (0 = largest)
//   o_last     : marks rank W-1
//   o_ovf      : sticky, set when a frame was dropped on a full FIFO
//   o_level    : frames currently queued
module sort_drain
  import sort_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_vld,
  input  logic [W*N-1:0]             i_y_q,
  output logic [N-1:0]               o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [clog2(W)-1:0]        o_idx,
  output logic                       o_last,
  output logic                       o_ovf,
  output logic [clog2(FIFO_DEPTH):0] o_level
);

  localparam int IW = clog2(W);
  localparam int LW = clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  frame_t         frame_al;
  frame_t         head;
  logic [W*N-1:0] head_raw;
  logic [W-1:0]   vld_sr;
  logic           push_req;
  logic           push_ok;
  logic           pop;
  logic           hs;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LW-1:0]  level_nxt;
  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [IW-1:0]  idx;
  logic           ovf;

  // Deskew: lane g gets W-1-g delay stages so every lane lines up with
  // the last one, which arrives W cycles after entry.
  for (genvar g = 0; g < W; g++) begin : g_lane
    if (g == W-1) begin : g_direct
      assign frame_al[g] = i_y_q[g*N +: N];
    end else begin : g_dly
      logic [N-1:0] dly [W-1-g];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < W-1-g; k++) dly[k] <= '0;
        end else begin
          dly[0] <= i_y_q[g*N +: N];
          for (int k = 1; k < W-1-g; k++) dly[k] <= dly[k-1];
        end
      end
      assign frame_al[g] = dly[W-2-g];
    end
  end

  // Valid tag travels W stages so it marks the aligned frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= {vld_sr[W-2:0], i_vld};
  end

  assign push_req = vld_sr[W-1];

  // Frame queue / serializer boundary
  assign o_valid = (state == SEND);
  assign hs      = o_valid && i_ready;
  assign pop     = hs && (idx == IW'(W-1));
  assign push_ok = push_req && (!fifo_full || pop);

  sort_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .FW    (W*N)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (frame_al),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  assign level_nxt = o_level + LW'(push_ok) - LW'(pop);

  // The FSM looks at the occupancy the FIFO will have after this edge, so
  // a frame written this cycle is already being presented next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty || push_ok) state_nxt = SEND;
      SEND:    if (pop && (level_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) idx <= (idx == IW'(W-1)) ? '0 : idx + 1'b1;
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  assign head   = head_raw;
  assign o_data = o_valid ? head[idx] : '0;
  assign o_idx  = idx;
  assign o_last = o_valid && (idx == IW'(W-1));
  assign o_ovf  = ovf;

endmodule

// File: tb/tb_sort_drain.sv
// tb_sort_drain -- randomized and directed bench for sort_drain. The bench
// plays the sort pipeline (skewed lanes from the sorted top-W of each
// vector) and keeps a frame-queue reference model of the drain.
module tb_sort_drain;
  import sort_pkg::*;

  localparam int D    = 4;
  localparam int IW   = clog2(W);
  localparam int LW   = clog2(D) + 1;
  localparam int MAXC = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_vld = 1'b0;
  logic             i_ready = 1'b0;
  logic [W*N-1:0]   i_y_q = '0;
  logic [N-1:0]     o_data;
  logic             o_valid;
  logic [IW-1:0]    o_idx;
  logic             o_last;
  logic             o_ovf;
  logic [LW-1:0]    o_level;

  always #5 clk = ~clk;

  sort_drain #(.FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vld   (i_vld),
    .i_y_q   (i_y_q),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_idx   (o_idx),
    .o_last  (o_last),
    .o_ovf   (o_ovf),
    .o_level (o_level)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W*N-1:0] top_hist [MAXC];
  bit             vld_hist [MAXC];
  int             cyc = 0;

  logic [W*N-1:0] mq [$];
  int             m_idx = 0;
  bit             m_ovf = 1'b0;

  int             bt_cyc [$];
  logic [N-1:0]   bt_dat [$];

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Top W elements of a vector, largest in lane 0.
  function automatic logic [W*N-1:0] top_w(input logic [M*N-1:0] vec);
    logic [N-1:0]   a [M];
    logic [N-1:0]   t;
    logic [W*N-1:0] r;
    for (int i = 0; i < M; i++) a[i] = vec[i*N +: N];
    for (int i = 0; i < W; i++)
      for (int j = i + 1; j < M; j++)
        if (a[j] > a[i]) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
    for (int i = 0; i < W; i++) r[i*N +: N] = a[i];
    return r;
  endfunction

  function automatic logic [M*N-1:0] rand_vec();
    logic [M*N-1:0] v;
    logic [31:0]    r;
    for (int i = 0; i < M; i++) begin
      r = $urandom;
      v[i*N +: N] = r[N-1:0];
    end
    return v;
  endfunction

  task automatic drive(input bit vld, input logic [M*N-1:0] vec, input bit rdy);
    logic [W*N-1:0] y;
    logic [W*N-1:0] h;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    top_hist[cyc] = top_w(vec);
    vld_hist[cyc] = vld;
    y = '0;
    for (int i = 0; i < W; i++)
      if (cyc - 1 - i >= 0) begin
        h = top_hist[cyc - 1 - i];
        y[i*N +: N] = h[i*N +: N];
      end
    i_y_q   = y;
    i_vld   = vld;
    i_ready = rdy;
  endtask

  task automatic model_check();
    bit             ev;
    bit             hs;
    bit             popf;
    bit             full;
    logic [W*N-1:0] hf;
    ev = (mq.size() != 0);
    check_val("o_valid", 64'(o_valid), 64'(ev));
    if (ev) begin
      hf = mq[0];
      check_val("o_data", 64'(o_data), 64'(hf[m_idx*N +: N]));
      check_val("o_idx", 64'(o_idx), 64'(m_idx));
      check_val("o_last", 64'(o_last), 64'(m_idx == W-1));
    end
    check_val("o_level", 64'(o_level), 64'(mq.size()));
    check_val("o_ovf", 64'(o_ovf), 64'(m_ovf));
    if (o_valid && i_ready) begin
      bt_cyc.push_back(cyc);
      bt_dat.push_back(o_data);
    end
    hs   = ev && i_ready;
    popf = hs && (m_idx == W-1);
    full = (mq.size() == D);
    if (hs) m_idx = (m_idx + 1) % W;
    if (popf) void'(mq.pop_front());
    if (cyc >= W && vld_hist[cyc - W]) begin
      if (full && !popf) m_ovf = 1'b1;
      else mq.push_back(top_hist[cyc - W]);
    end
  endtask

  task automatic step(input bit vld, input logic [M*N-1:0] vec, input bit rdy);
    @(posedge clk);
    #1;
    cyc++;
    drive(vld, vec, rdy);
    @(negedge clk);
    if (rst_n) model_check();
  endtask

  task automatic pulse_reset(input int exp_idx);
    @(posedge clk);
    #1;
    cyc++;
    drive(1'b0, '0, 1'b1);
    #2;
    check_val("idx_before_rst", 64'(o_idx), 64'(exp_idx));
    rst_n = 1'b0;
    #1;
    check_val("rst_o_valid", 64'(o_valid), 64'(0));
    check_val("rst_o_data", 64'(o_data), 64'(0));
    check_val("rst_o_idx", 64'(o_idx), 64'(0));
    check_val("rst_o_last", 64'(o_last), 64'(0));
    check_val("rst_o_level", 64'(o_level), 64'(0));
    mq.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < MAXC; k++) vld_hist[k] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    drive(1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    model_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [M*N-1:0] va;
    int             exp4 [4];
    int             t;
    bit             hit;

    va = {8'd9, 8'd3, 8'd7, 8'd1, 8'd15, 8'd0, 8'd2, 8'd4};
    exp4 = '{15, 9, 7, 4};

    #12;
    check_val("reset_valid", 64'(o_valid), 64'(0));
    check_val("reset_data", 64'(o_data), 64'(0));
    check_val("reset_idx", 64'(o_idx), 64'(0));
    check_val("reset_last", 64'(o_last), 64'(0));
    check_val("reset_ovf", 64'(o_ovf), 64'(0));
    check_val("reset_level", 64'(o_level), 64'(0));
    #1;
    rst_n = 1'b1;

    // single vector, latency and rank order
    bt_cyc.delete(); bt_dat.delete();
    t = cyc + 1;
    step(1'b1, va, 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);
    check_val("single_beats", 64'(bt_dat.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < bt_dat.size()) begin
        check_val("single_data", 64'(bt_dat[k]), 64'(exp4[k]));
        check_val("single_cycle", 64'(bt_cyc[k]), 64'(t + 5 + k));
      end

    // back-to-back frames, no bubble
    bt_cyc.delete(); bt_dat.delete();
    t = cyc + 1;
    step(1'b1, rand_vec(), 1'b1);
    step(1'b1, rand_vec(), 1'b1);
    repeat (12) step(1'b0, '0, 1'b1);
    check_val("b2b_beats", 64'(bt_dat.size()), 64'(8));
    if (bt_cyc.size() == 8) begin
      check_val("b2b_first", 64'(bt_cyc[0]), 64'(t + 5));
      for (int k = 1; k < 8; k++)
        check_val("b2b_gap", 64'(bt_cyc[k] - bt_cyc[0]), 64'(k));
    end

    // backpressure on the first beat
    bt_cyc.delete(); bt_dat.delete();
    t = cyc + 1;
    step(1'b1, va, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1);
    check_val("stall_beats", 64'(bt_dat.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < bt_dat.size()) begin
        check_val("stall_data", 64'(bt_dat[k]), 64'(exp4[k]));
        check_val("stall_cycle", 64'(bt_cyc[k]), 64'(t + 8 + k));
      end

    // overflow: five frames into a four-deep FIFO
    bt_cyc.delete(); bt_dat.delete();
    repeat (5) step(1'b1, rand_vec(), 1'b0);
    repeat (W + 2) step(1'b0, '0, 1'b0);
    check_val("ovf_level", 64'(o_level), 64'(4));
    check_val("ovf_flag", 64'(o_ovf), 64'(1));
    repeat (24) step(1'b0, '0, 1'b1);
    check_val("ovf_beats", 64'(bt_dat.size()), 64'(16));
    check_val("ovf_sticky", 64'(o_ovf), 64'(1));

    // reset mid-frame at rank 2
    step(1'b1, va, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (mq.size() != 0 && m_idx == 2) hit = 1'b1;
      else step(1'b0, '0, 1'b1);
    end
    check_val("reach_idx2", 64'(hit), 64'(1));
    pulse_reset(2);
    bt_cyc.delete(); bt_dat.delete();
    repeat (10) step(1'b0, '0, 1'b1);
    check_val("no_stale_beats", 64'(bt_dat.size()), 64'(0));
    step(1'b1, va, 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);
    check_val("post_rst_beats", 64'(bt_dat.size()), 64'(4));

    // full FIFO, push coincides with the head frame's last beat
    bt_cyc.delete(); bt_dat.delete();
    repeat (4) step(1'b1, rand_vec(), 1'b0);
    repeat (6) step(1'b0, '0, 1'b0);
    check_val("full_level", 64'(o_level), 64'(4));
    step(1'b1, rand_vec(), 1'b0);
    repeat (24) step(1'b0, '0, 1'b1);
    check_val("full_pop_ovf", 64'(o_ovf), 64'(0));
    check_val("full_pop_beats", 64'(bt_dat.size()), 64'(20));

    // randomized traffic
    repeat (500) step($urandom_range(0, 9) < 4, rand_vec(), $urandom_range(0, 9) < 7);
    repeat (40) step(1'b0, '0, 1'b1);
    check_val("drain_level", 64'(o_level), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
